// File: rtl/sa_sc_fifo_flags.sv
// Show-ahead single-clock FIFO with occupancy count, programmable almost flags
// and sticky overflow/underflow error flags.
module sa_sc_fifo_flags #(
  parameter int DataWidth     = 8,
  parameter int AddrWidth     = 4,
  parameter int AlmostFullTh  = 2**AddrWidth - 2,
  parameter int AlmostEmptyTh = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclr,
  input  logic                 we,
  input  logic [DataWidth-1:0] d,
  input  logic                 ack,
  output logic [DataWidth-1:0] q,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic [AddrWidth:0]   usedw,
  output logic                 ovf,
  output logic                 udf
);

  localparam int Depth = 2**AddrWidth;
  localparam logic [AddrWidth:0]   LP_DEPTH   = (AddrWidth+1)'(Depth);
  localparam logic [AddrWidth:0]   LP_CNT_ONE = (AddrWidth+1)'(1);
  localparam logic [AddrWidth-1:0] LP_PTR_ONE = AddrWidth'(1);
  localparam logic [AddrWidth:0]   LP_AF_TH   = (AddrWidth+1)'(AlmostFullTh);
  localparam logic [AddrWidth:0]   LP_AE_TH   = (AddrWidth+1)'(AlmostEmptyTh);

  generate
    if (DataWidth < 1) begin : g_bad_data_width
      $fatal(1, "sa_sc_fifo_flags: DataWidth must be >= 1");
    end
    if (AddrWidth < 1) begin : g_bad_addr_width
      $fatal(1, "sa_sc_fifo_flags: AddrWidth must be >= 1");
    end
    if (AlmostFullTh < 1 || AlmostFullTh > Depth) begin : g_bad_af_th
      $fatal(1, "sa_sc_fifo_flags: AlmostFullTh out of range 1..Depth");
    end
    if (AlmostEmptyTh < 0 || AlmostEmptyTh > Depth - 1) begin : g_bad_ae_th
      $fatal(1, "sa_sc_fifo_flags: AlmostEmptyTh out of range 0..Depth-1");
    end
  endgenerate

  logic [DataWidth-1:0] r_mem [Depth];
  logic [AddrWidth-1:0] r_wr_ptr;
  logic [AddrWidth-1:0] r_rd_ptr;
  logic [AddrWidth:0]   r_usedw;
  logic                 r_ovf;
  logic                 r_udf;

  logic w_empty;
  logic w_full;
  logic w_wr_acc;
  logic w_rd_acc;

  assign w_empty  = (r_usedw == '0);
  assign w_full   = (r_usedw == LP_DEPTH);
  // A pop frees the slot in the same edge, so a full FIFO still takes a write alongside ack.
  assign w_wr_acc = we & (~w_full | ack);
  assign w_rd_acc = ack & ~w_empty;

  always_ff @(posedge clk) begin
    if (!rst && !sclr && w_wr_acc) begin
      r_mem[r_wr_ptr] <= d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usedw  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (sclr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usedw  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      end
      if (w_wr_acc && !w_rd_acc) begin
        r_usedw <= r_usedw + LP_CNT_ONE;
      end else if (w_rd_acc && !w_wr_acc) begin
        r_usedw <= r_usedw - LP_CNT_ONE;
      end
      if (we && !w_wr_acc) begin
        r_ovf <= 1'b1;
      end
      if (ack && w_empty) begin
        r_udf <= 1'b1;
      end
    end
  end

  assign q            = w_empty ? '0 : r_mem[r_rd_ptr];
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_empty = (r_usedw <= LP_AE_TH);
  assign almost_full  = (r_usedw >= LP_AF_TH);
  assign usedw        = r_usedw;
  assign ovf          = r_ovf;
  assign udf          = r_udf;

endmodule

// File: tb/tb_sa_sc_fifo_flags.sv
// Scoreboard bench for sa_sc_fifo_flags: the driver predicts each cycle's outputs
// from a queue model and a separate monitor compares after every rising edge.
module tb_sa_sc_fifo_flags;

  typedef struct packed {
    logic [7:0] q;
    logic [4:0] usedw;
    logic       empty;
    logic       full;
    logic       ae;
    logic       af;
    logic       ovf;
    logic       udf;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclr = 1'b0;
  logic       we = 1'b0;
  logic [7:0] d = 8'h00;
  logic       ack = 1'b0;
  logic [7:0] q;
  logic       empty, full, almost_empty, almost_full, ovf, udf;
  logic [4:0] usedw;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  obs_t       exp_q[$];
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  sa_sc_fifo_flags #(
    .DataWidth(8), .AddrWidth(4), .AlmostFullTh(14), .AlmostEmptyTh(1)
  ) dut (
    .clk(clk), .rst(rst), .sclr(sclr), .we(we), .d(d), .ack(ack),
    .q(q), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .usedw(usedw), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o = {q, usedw, empty, full, almost_empty, almost_full, ovf, udf};
    return o;
  endfunction

  function automatic obs_t predict();
    obs_t o;
    int n;
    n = mq.size();
    o.q     = (n > 0) ? mq[0] : 8'h00;
    o.usedw = 5'(n);
    o.empty = (n == 0);
    o.full  = (n == 16);
    o.ae    = (n <= 1);
    o.af    = (n >= 14);
    o.ovf   = m_ovf;
    o.udf   = m_udf;
    return o;
  endfunction

  task automatic chk(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got q=%h usedw=%0d e=%b f=%b ae=%b af=%b ovf=%b udf=%b want q=%h usedw=%0d e=%b f=%b ae=%b af=%b ovf=%b udf=%b",
               name, act.q, act.usedw, act.empty, act.full, act.ae, act.af, act.ovf, act.udf,
               exp.q, exp.usedw, exp.empty, exp.full, exp.ae, exp.af, exp.ovf, exp.udf);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the coming edge.
  task automatic step(input logic w, input logic [7:0] dd, input logic a, input logic s);
    logic was_full, was_empty, wacc, racc;
    @(negedge clk);
    we = w; d = dd; ack = a; sclr = s;
    if (s) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      was_full  = (mq.size() == 16);
      was_empty = (mq.size() == 0);
      wacc = w && (!was_full || a);
      racc = a && !was_empty;
      if (w && !wacc) m_ovf = 1'b1;
      if (a && was_empty) m_udf = 1'b1;
      if (racc) void'(mq.pop_front());
      if (wacc) mq.push_back(dd);
    end
    exp_q.push_back(predict());
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() > 0) begin
      cyc++;
      chk($sformatf("cyc%0d", cyc), sample(), exp_q.pop_front());
    end
  end

  initial begin
    obs_t reset_obs;
    int r;
    reset_obs = '{q: 8'h00, usedw: 5'd0, empty: 1'b1, full: 1'b0, ae: 1'b1, af: 1'b0, ovf: 1'b0, udf: 1'b0};
    #12;
    chk("reset_state", sample(), reset_obs);
    @(negedge clk);
    rst = 1'b0;

    // Fill 0x01..0x10, then push+pop while full, then a rejected write.
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h11, 1'b1, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    // sclr wins over a concurrent write.
    step(1'b1, 8'h77, 1'b0, 1'b1);

    // Refill and drain in order.
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // ack on empty with a write, then push+pop at usedw=1, then drain.
    step(1'b1, 8'h42, 1'b1, 1'b0);
    step(1'b1, 8'h43, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Wrap-around: occupancy held between 4 and 5 for many pointer laps.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 60; i++)
      step((i % 3) != 2, 8'(8'hC0 + i), (i % 3) != 0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle at usedw=7.
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    @(negedge clk);
    we = 1'b0; ack = 1'b0;
    exp_q.push_back(predict());
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_reset", sample(), reset_obs);
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Random regression.
    for (int i = 0; i < 1000; i++) begin
      r = $urandom_range(0, 99);
      step(r < 44, 8'($urandom), $urandom_range(0, 99) < 14, $urandom_range(0, 99) < 4);
    end

    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got pending=%0d want pending=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
